// File: rtl/console_writer_if.sv
// console_writer_if
//   Bundles the character input handshake, the character-plane write port
//   and the cursor/status outputs of console_writer.
//   slave  : the console_writer side (consumes characters, drives the plane).
//   master : the character source / observer side.
//   Signals:
//     char_in[7:0], char_valid  -> character offer
//     char_ready                <- character accepted this cycle
//     wr_data[7:0], wr_row[3:0], wr_col[4:0], wr_en <- 16x32 plane write port
//     cursor_row[3:0], cursor_col[4:0]              <- current cursor
//     busy                                          <- clear sweep running
interface console_writer_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] wr_data;
    logic [3:0] wr_row;
    logic [4:0] wr_col;
    logic       wr_en;
    logic [3:0] cursor_row;
    logic [4:0] cursor_col;
    logic       busy;

    modport slave (
        input  char_in, char_valid,
        output char_ready, wr_data, wr_row, wr_col, wr_en,
               cursor_row, cursor_col, busy
    );

    modport master (
        output char_in, char_valid,
        input  char_ready, wr_data, wr_row, wr_col, wr_en,
               cursor_row, cursor_col, busy
    );
endinterface

// File: rtl/console_writer.sv
// console_writer
//   Turns a stream of character codes into writes on a 16x32 character
//   plane. Printable codes are written at the cursor and advance it (with
//   wrap to (0,0), no scrolling); LF, CR and BS move the cursor; FF starts a
//   512-cell clear sweep that writes FILL_CHAR row-major and homes the cursor.
//   All outputs are registered.
//   Ports:
//     clock   - single clock, rising edge
//     reset_n - asynchronous active-low reset
//     bus     - console_writer_if.slave (character handshake, plane write
//               port, cursor position, busy)
//   Parameter:
//     FILL_CHAR - character written by clear and backspace (default 8'h20)
//   Optional feature:
//     CONSOLE_CLEAR_ON_RESET_EN - when defined, the first edge after reset
//     release starts a full clear sweep before any character is accepted.
module console_writer #(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic             clock,
    input  logic             reset_n,
    console_writer_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

`ifdef CONSOLE_CLEAR_ON_RESET_EN
    localparam logic START_ON_RESET = 1'b1;
`else
    localparam logic START_ON_RESET = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [8:0] sweep_q, sweep_d;     // cell index being written by the sweep
    logic       start_q, start_d;     // sweep requested by reset release
    logic [7:0] wr_data_q, wr_data_d;
    logic [8:0] wr_addr_q, wr_addr_d; // {row, col}, row-major linear index
    logic       wr_en_q, wr_en_d;
    logic [8:0] cursor_q, cursor_d;   // {row, col}; +1/-1 gives the wrap rules
    logic       char_ready_q, char_ready_d;
    logic       busy_q, busy_d;

    logic       accept_s;
    logic       printable_s;

    assign accept_s    = bus.char_valid & char_ready_q;
    assign printable_s = ((bus.char_in >= 8'h20) && (bus.char_in <= 8'h7E)) ||
                         (bus.char_in >= 8'h80);

    // State register and all registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sweep_q      <= 9'd0;
            start_q      <= START_ON_RESET;
            wr_data_q    <= 8'h00;
            wr_addr_q    <= 9'd0;
            wr_en_q      <= 1'b0;
            cursor_q     <= 9'd0;
            char_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            start_q      <= start_d;
            wr_data_q    <= wr_data_d;
            wr_addr_q    <= wr_addr_d;
            wr_en_q      <= wr_en_d;
            cursor_q     <= cursor_d;
            char_ready_q <= char_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic: sweep start on FF (or reset release), sweep progress
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        start_d = start_q;
        case (state_q)
            IDLE: begin
                if (start_q) begin
                    state_d = CLEAR;
                    sweep_d = 9'd0;
                    start_d = 1'b0;
                end else if (accept_s && (bus.char_in == 8'h0C)) begin
                    state_d = CLEAR;
                    sweep_d = 9'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (sweep_q == 9'd511) begin
                    state_d = IDLE;
                end else begin
                    sweep_d = sweep_q + 9'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: computed from the next state so each output appears
    // in the same cycle the corresponding state is entered
    always_comb begin
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        wr_addr_d    = wr_addr_q;
        cursor_d     = cursor_q;
        char_ready_d = (state_d == IDLE);
        busy_d       = (state_d == CLEAR);
        if (state_d == CLEAR) begin
            wr_en_d   = 1'b1;
            wr_data_d = FILL_CHAR;
            wr_addr_d = sweep_d;
            cursor_d  = 9'd0;
        end else if (accept_s) begin
            case (bus.char_in)
                8'h0A: cursor_d = {cursor_q[8:5] + 4'd1, 5'd0};
                8'h0D: cursor_d = {cursor_q[8:5], 5'd0};
                8'h08: begin
                    // Step back one cell (row-major); nothing at home
                    if (cursor_q != 9'd0) begin
                        cursor_d  = cursor_q - 9'd1;
                        wr_en_d   = 1'b1;
                        wr_data_d = FILL_CHAR;
                        wr_addr_d = cursor_q - 9'd1;
                    end else begin
                        cursor_d = cursor_q;
                    end
                end
                default: begin
                    if (printable_s) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = bus.char_in;
                        wr_addr_d = cursor_q;
                        cursor_d  = cursor_q + 9'd1;
                    end else begin
                        cursor_d = cursor_q;
                    end
                end
            endcase
        end else begin
            cursor_d = cursor_q;
        end
    end

    assign bus.char_ready = char_ready_q;
    assign bus.busy       = busy_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.wr_row     = wr_addr_q[8:5];
    assign bus.wr_col     = wr_addr_q[4:0];
    assign bus.cursor_row = cursor_q[8:5];
    assign bus.cursor_col = cursor_q[4:0];

endmodule

// File: tb/tb_console_writer.sv
// tb_console_writer
//   Drives console_writer with directed and random character streams and
//   compares every output on every cycle against a behavioural model that
//   tracks the cursor as (row, col) integers and the clear sweep as a cell
//   count. Directed sections also check hand-computed literal values.
module tb_console_writer;

    localparam logic [7:0] FILL = 8'h20;
`ifdef CONSOLE_CLEAR_ON_RESET_EN
    localparam bit CLR_RST = 1'b1;
`else
    localparam bit CLR_RST = 1'b0;
`endif

    logic clock;
    logic reset_n;
    console_writer_if bus ();

    console_writer #(.FILL_CHAR(FILL)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;
    bit cmp_en     = 1'b0;

    // model state
    int m_sweep;            // -1 when not sweeping, else cell being written
    bit m_pend;
    bit m_ready, m_busy, m_wen;
    int m_wrow, m_wcol, m_wdata, m_crow, m_ccol;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit printable(input logic [7:0] c);
        return ((c >= 8'h20) && (c <= 8'h7E)) || (c >= 8'h80);
    endfunction

    task automatic model_reset();
        m_sweep = -1; m_pend = CLR_RST;
        m_ready = 0; m_busy = 0; m_wen = 0;
        m_wrow = 0; m_wcol = 0; m_wdata = 0; m_crow = 0; m_ccol = 0;
    endtask

    task automatic model_write(input int r, input int c, input int d);
        m_wen = 1; m_wrow = r; m_wcol = c; m_wdata = d;
    endtask

    task automatic start_sweep();
        m_sweep = 0; m_ready = 0; m_busy = 1; m_crow = 0; m_ccol = 0;
        model_write(0, 0, FILL);
    endtask

    // one rising edge of the model, using the inputs the bench applied
    task automatic model_step();
        logic [7:0] c;
        c = bus.char_in;
        if (reset_n) begin
            m_wen = 0;
            if (m_sweep >= 0) begin
                if (m_sweep == 511) begin
                    m_sweep = -1; m_ready = 1; m_busy = 0; m_crow = 0; m_ccol = 0;
                end else begin
                    m_sweep++;
                    model_write(m_sweep / 32, m_sweep % 32, FILL);
                end
            end else if (m_pend) begin
                m_pend = 0;
                start_sweep();
            end else if (!m_ready) begin
                m_ready = 1;
            end else if (bus.char_valid) begin
                if (c == 8'h0A) begin
                    m_ccol = 0; m_crow = (m_crow + 1) % 16;
                end else if (c == 8'h0D) begin
                    m_ccol = 0;
                end else if (c == 8'h08) begin
                    if (m_ccol > 0) begin
                        m_ccol--; model_write(m_crow, m_ccol, FILL);
                    end else if (m_crow > 0) begin
                        m_crow--; m_ccol = 31; model_write(m_crow, m_ccol, FILL);
                    end
                end else if (c == 8'h0C) begin
                    start_sweep();
                end else if (printable(c)) begin
                    model_write(m_crow, m_ccol, c);
                    m_ccol++;
                    if (m_ccol == 32) begin
                        m_ccol = 0; m_crow = (m_crow + 1) % 16;
                    end
                end
            end
        end
    endtask

    // apply one cycle of input, advance the model, sample 1 time unit later
    task automatic send(input logic [7:0] c, input logic v);
        @(negedge clock);
        bus.char_in = c;
        bus.char_valid = v;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n = 1'b1;
        bus.char_valid = 1'b0;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 1000 && !m_ready; i++) send(8'h00, 1'b0);
        chk("wait_ready", bus.char_ready, 1);
    endtask

    task automatic chk_cursor(input string name, input int r, input int c);
        chk({name, "_row"}, bus.cursor_row, r);
        chk({name, "_col"}, bus.cursor_col, c);
    endtask

    task automatic chk_wr(input string name, input int r, input int c, input int d);
        chk({name, "_wen"}, bus.wr_en, 1);
        chk({name, "_row"}, bus.wr_row, r);
        chk({name, "_col"}, bus.wr_col, c);
        chk({name, "_data"}, bus.wr_data, d);
    endtask

    // every-cycle comparison against the model
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("ready", bus.char_ready, m_ready);
            chk("busy", bus.busy, m_busy);
            chk("wr_en", bus.wr_en, m_wen);
            chk("wr_data", bus.wr_data, m_wdata);
            chk("wr_row", bus.wr_row, m_wrow);
            chk("wr_col", bus.wr_col, m_wcol);
            chk("cur_row", bus.cursor_row, m_crow);
            chk("cur_col", bus.cursor_col, m_ccol);
        end
    end

    initial begin
        logic [7:0] c;
        bit v;
        reset_n = 1'b0;
        bus.char_in = 8'h00;
        bus.char_valid = 1'b0;
        model_reset();
        #1;
        cmp_en = 1'b1;
        chk("rst_ready", bus.char_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wen", bus.wr_en, 0);
        chk("rst_wdata", bus.wr_data, 0);
        chk_cursor("rst_cur", 0, 0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        release_reset();
        chk("first_edge_busy", bus.busy, CLR_RST ? 1 : 0);
        wait_ready();

        // 'A','B' back to back
        send(8'h41, 1'b1); chk_wr("wrA", 0, 0, 8'h41);
        send(8'h42, 1'b1); chk_wr("wrB", 0, 1, 8'h42);
        send(8'h00, 1'b0);
        chk("idle_wen", bus.wr_en, 0);
        chk("hold_data", bus.wr_data, 8'h42);
        chk_cursor("ab_cur", 0, 2);

        // move to (5,7), then LF, CR, BEL
        send(8'h0D, 1'b1);
        for (int i = 0; i < 5; i++) send(8'h0A, 1'b1);
        for (int i = 0; i < 7; i++) send(8'h2E, 1'b1);
        chk_cursor("pos57", 5, 7);
        send(8'h0A, 1'b1); chk_cursor("lf", 6, 0); chk("lf_wen", bus.wr_en, 0);
        send(8'h0D, 1'b1); chk_cursor("cr", 6, 0); chk("cr_wen", bus.wr_en, 0);
        send(8'h07, 1'b1); chk_cursor("bel", 6, 0); chk("bel_wen", bus.wr_en, 0);

        // backspace across a row boundary, then at home
        for (int i = 0; i < 13; i++) send(8'h0A, 1'b1);
        chk_cursor("pos30", 3, 0);
        send(8'h08, 1'b1); chk_wr("bs_wrap", 2, 31, 8'h20); chk_cursor("bs_cur", 2, 31);
        for (int i = 0; i < 14; i++) send(8'h0A, 1'b1);
        send(8'h08, 1'b1); chk("bs_home_wen", bus.wr_en, 0); chk_cursor("bs_home", 0, 0);

        // last cell wraps to (0,0)
        for (int i = 0; i < 15; i++) send(8'h0A, 1'b1);
        for (int i = 0; i < 31; i++) send(8'h2E, 1'b1);
        chk_cursor("pos1531", 15, 31);
        send(8'h5A, 1'b1); chk_wr("wr_last", 15, 31, 8'h5A); chk_cursor("wrap", 0, 0);

        // full clear sweep with char_valid held high
        send(8'h0C, 1'b1);
        chk_wr("sweep0", 0, 0, FILL);
        chk("sweep0_ready", bus.char_ready, 0);
        for (int i = 1; i < 512; i++) begin
            send(8'h51, 1'b1);
            chk("sweep_row", bus.wr_row, i / 32);
            chk("sweep_col", bus.wr_col, i % 32);
            chk("sweep_ready", bus.char_ready, 0);
        end
        send(8'h51, 1'b1);
        chk("sweep_end_ready", bus.char_ready, 1);
        chk("sweep_end_wen", bus.wr_en, 0);
        chk_cursor("sweep_end", 0, 0);
        send(8'h51, 1'b1);
        chk_wr("after_sweep", 0, 0, 8'h51);
        send(8'h00, 1'b0);

        // reset in the middle of a sweep
        send(8'h0C, 1'b1);
        for (int i = 1; i < 100; i++) send(8'h00, 1'b0);
        chk_wr("sweep99", 3, 3, FILL);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("abort_wen", bus.wr_en, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_ready", bus.char_ready, 0);
        send(8'h00, 1'b0);
        release_reset();
        chk("post_abort_busy", bus.busy, CLR_RST ? 1 : 0);
        chk("post_abort_ready", bus.char_ready, CLR_RST ? 0 : 1);
        wait_ready();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10) begin
                case ($urandom_range(0, 7))
                    0: c = 8'h0A;
                    1: c = 8'h0D;
                    2: c = 8'h08;
                    3: c = 8'h08;
                    4: c = 8'h07;
                    5: c = 8'h00;
                    6: c = 8'h7F;
                    default: c = 8'h1B;
                endcase
            end else if (r == 10 && $urandom_range(0, 5) == 0) begin
                c = 8'h0C;
            end else begin
                c = 8'($urandom_range(0, 255));
                if (c == 8'h0C) c = 8'h41;
            end
            v = ($urandom_range(0, 9) < 7);
            send(c, v);
        end
        send(8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/console_writer.md
CONSOLE_WRITER -- requirements
Module: console_writer

Interface
REQ-001 The block SHALL have parameter FILL_CHAR, default 8'h20, the character written by clear and backspace.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port char_in, input, 8, the incoming character code.
REQ-005 The block SHALL have port char_valid, input, 1, meaning char_in is offered.
REQ-006 The block SHALL have port char_ready, output, 1, meaning the block accepts char_in this cycle.
REQ-007 The block SHALL have port wr_data, output, 8, character id to the 16x32 character plane write port.
REQ-008 The block SHALL have port wr_row, output, 4, plane write row.
REQ-009 The block SHALL have port wr_col, output, 5, plane write column.
REQ-010 The block SHALL have port wr_en, output, 1, plane write strobe, sampled by the plane on the next clock edge.
REQ-011 The block SHALL have ports cursor_row (output, 4) and cursor_col (output, 5), the current cursor position.
REQ-012 The block SHALL have port busy, output, 1, high while a clear sweep runs.

Function
REQ-013 The FSM SHALL have states IDLE and CLEAR; all outputs SHALL be registered.
REQ-014 In IDLE, char_ready SHALL be 1; in CLEAR, char_ready SHALL be 0 and busy SHALL be 1.
REQ-015 A character SHALL be accepted on a rising edge where char_valid and char_ready are both 1; back-to-back acceptance every cycle SHALL be supported.
REQ-016 For a printable code (0x20-0x7E, 0x80-0xFF), the block SHALL drive wr_en=1 for exactly one cycle after acceptance, with wr_data=char_in at the pre-advance cursor, and SHALL advance the cursor on the same edge.
REQ-017 Cursor advance SHALL be col+1; at col 31 it SHALL go to col 0, row+1; at (15,31) it SHALL wrap to (0,0), with no scrolling.
REQ-018 On 0x0A, the cursor SHALL go to col 0, row+1 mod 16, with no write.
REQ-019 On 0x0D, the cursor SHALL go to col 0, with the row unchanged and no write.
REQ-020 On 0x08 at col>0, the cursor SHALL go to col-1 and FILL_CHAR SHALL be written there; at col 0 with row>0, the cursor SHALL go to (row-1,31) and FILL_CHAR SHALL be written there; at (0,0), there SHALL be no move and no write.
REQ-021 On 0x0C, the block SHALL enter CLEAR on the next edge.
REQ-022 In CLEAR, the block SHALL write FILL_CHAR to each of the 512 cells, one per cycle, row-major from (0,0) to (15,31); the cycle after the (15,31) write, it SHALL return to IDLE with the cursor at (0,0).
REQ-023 Any other code (0x00-0x1F not listed, 0x7F) SHALL be accepted and discarded, with no write and no cursor change.
REQ-024 When no character is accepted in IDLE, wr_en SHALL be 0; wr_row, wr_col and wr_data SHALL hold their last values.

Reset
REQ-025 Asserting reset_n low SHALL immediately force state=IDLE, cursor=(0,0), wr_en=0, wr_data=0, wr_row=0, wr_col=0, busy=0 and char_ready=0.
REQ-026 char_ready SHALL become 1 on the first rising edge after reset_n deasserts, unless CONSOLE_CLEAR_ON_RESET_EN applies.
REQ-027 Reset asserted mid-CLEAR SHALL abort the sweep; the sweep SHALL NOT resume afterwards unless CONSOLE_CLEAR_ON_RESET_EN applies.

Configuration
REQ-028 With macro CONSOLE_CLEAR_ON_RESET_EN defined, the first edge after reset_n deasserts SHALL enter CLEAR and perform the full 512-cycle sweep before any character is accepted.
REQ-029 With CONSOLE_CLEAR_ON_RESET_EN undefined, the block SHALL enter IDLE after reset and leave plane contents untouched.

Verification
REQ-030 Reset, then offer 'A' (0x41) and 'B' (0x42) on consecutive cycles -> wr_en pulses carry (0,0,0x41) then (0,1,0x42); the cursor ends at (0,2).
REQ-031 From cursor (15,31), offer 0x5A -> write of 0x5A at (15,31); the cursor becomes (0,0).
REQ-032 From cursor (3,0), offer 0x08 -> write of 0x20 at (2,31); the cursor becomes (2,31). From (0,0), offer 0x08 -> no wr_en and no cursor change.
REQ-033 Offer 0x0C with char_valid held high -> char_ready=0 for 512 cycles; wr_en stays high across the sweep, covering addresses (0,0)..(15,31) in order; the cursor ends at (0,0); the next character is accepted afterwards.
REQ-034 Assert reset_n at sweep cycle 100 -> wr_en and busy drop immediately; after release the block is in IDLE without CONSOLE_CLEAR_ON_RESET_EN, or runs a fresh 512-cycle sweep with it.
REQ-035 From cursor (5,7), offer 0x0A, 0x0D and 0x07 -> the cursor goes (6,0), (6,0), (6,0), with no writes.
